soc_periph_fabric: RTL and testbench

Slave-side fabric for a picorv32-based SoC. It decodes the CPU native memory bus, serves a word-addressed on-chip SRAM and a 6-bit LED register, and exports a select/return port for an external UART. It also aggregates the slaves' ready and read data back to the core. It sits directly between the picorv32 memory port and the peripherals.

---
 rtl/soc_periph_fabric.sv | 143 ++++++++++++++
 tb/tb_soc_periph_fabric.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/soc_periph_fabric.sv
// Slave-side fabric for the picorv32 native bus: SRAM, LED register, UART port and error responder.
// Optional free-running cycle counter at 32'h8000_0010 is built when CYCLE_COUNTER_EN is defined.
module soc_periph_fabric #(
    parameter int          ADDR_WIDTH = 13,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [3:0]  leds,
    output logic        uart_sel,
    output logic [3:0]  uart_addr,
    input  logic        uart_ready,
    input  logic [31:0] uart_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic        sram_sel;
    logic        led_sel;
    logic        cnt_sel;
    logic        err_sel;
    logic        is_write;

    logic        sram_ready_reg;
    logic        led_ready_reg;
    logic        cnt_ready_reg;
    logic        err_ready_reg;

    logic [31:0] sram_offset;
    logic [ADDR_WIDTH-1:0] sram_idx;
    logic        sram_go;
    logic [31:0] sram_rdata;
    logic [31:0] mem_array [0:DEPTH-1];

    logic [5:0]  led_reg;
    logic [31:0] cnt_rdata;

    // Address decode; every select is qualified by mem_valid.
    assign is_write = (mem_wstrb != 4'b0000);
    assign sram_sel = mem_valid && (mem_addr < 32'h0002_0000);
    assign led_sel  = mem_valid && (mem_addr == 32'h8000_0000);
    assign uart_sel = mem_valid && ((mem_addr & 32'hFFFF_FFF8) == 32'h8000_0008);
    assign err_sel  = mem_valid && !(sram_sel || led_sel || uart_sel || cnt_sel);
    assign uart_addr = mem_addr[3:0];

    // SRAM: no reset on the array or its read register so it maps to block RAM.
    assign sram_offset = mem_addr - BASE_ADDR;
    assign sram_idx    = sram_offset[ADDR_WIDTH+1:2];
    // rst_n in the enable drops an access whose edge lands inside reset.
    assign sram_go     = sram_sel && !sram_ready_reg && rst_n;

    always_ff @(posedge clk_in) begin
        if (sram_go) begin
            if (is_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (mem_wstrb[i]) begin
                        mem_array[sram_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
                    end
                end
            end else begin
                sram_rdata <= mem_array[sram_idx];
            end
        end
    end

    // Ready pulses: set when selected and idle, cleared the following edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sram_ready_reg <= 1'b0;
            led_ready_reg  <= 1'b0;
            err_ready_reg  <= 1'b0;
        end else begin
            sram_ready_reg <= sram_sel && !sram_ready_reg;
            led_ready_reg  <= led_sel && !led_ready_reg;
            err_ready_reg  <= err_sel && !err_ready_reg;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            led_reg <= 6'd0;
        end else if (led_sel && !led_ready_reg && mem_wstrb[0]) begin
            led_reg <= mem_wdata[5:0];
        end
    end

    assign leds = ~led_reg[3:0];

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cnt_reg;
    logic [31:0] cnt_rdata_reg;

    assign cnt_sel   = mem_valid && (mem_addr == 32'h8000_0010);
    assign cnt_rdata = cnt_rdata_reg;

    // Writes to the counter complete but never modify it.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= 32'd0;
            cnt_rdata_reg <= 32'd0;
            cnt_ready_reg <= 1'b0;
        end else begin
            cnt_reg       <= cnt_reg + 32'd1;
            cnt_ready_reg <= cnt_sel && !cnt_ready_reg;
            if (cnt_sel && !cnt_ready_reg && !is_write) begin
                cnt_rdata_reg <= cnt_reg;
            end
        end
    end
`else
    assign cnt_sel       = 1'b0;
    assign cnt_rdata     = 32'd0;
    assign cnt_ready_reg = 1'b0;
`endif

    always_comb begin
        mem_rdata = 32'd0;
        if (sram_sel) begin
            mem_rdata = sram_rdata;
        end else if (led_sel) begin
            mem_rdata = {26'd0, led_reg};
        end else if (uart_sel) begin
            mem_rdata = uart_rdata;
        end else if (cnt_sel) begin
            mem_rdata = cnt_rdata;
        end
    end

    assign mem_ready = mem_valid && (sram_ready_reg || led_ready_reg || uart_ready ||
                                     cnt_ready_reg || err_ready_reg);

    // Bits that are decoded elsewhere or only passed through by the core.
    logic unused_bits;
    assign unused_bits = &{1'b0, mem_instr, sram_offset[31:ADDR_WIDTH+2], sram_offset[1:0]};

endmodule

// File: tb/tb_soc_periph_fabric.sv
// Directed self-checking bench for soc_periph_fabric (one line printed per bus transaction).
module tb_soc_periph_fabric;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [3:0]  leds;
    logic        uart_sel;
    logic [3:0]  uart_addr;
    logic        uart_ready;
    logic [31:0] uart_rdata;

    int checks = 0;
    int errors = 0;

    soc_periph_fabric #(.ADDR_WIDTH(13), .BASE_ADDR(32'h0000_0000)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .leds      (leds),
        .uart_sel  (uart_sel),
        .uart_addr (uart_addr),
        .uart_ready(uart_ready),
        .uart_rdata(uart_rdata)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called and returns at posedge+1. lat = edges until mem_ready; dropped = ready low one edge later.
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                            output logic [31:0] rdata, output int lat, output logic dropped);
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk_in);
            #1;
            lat++;
        end while (!mem_ready && lat < 8);
        rdata = mem_rdata;
        @(posedge clk_in);
        #1;
        dropped = !mem_ready;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        $display("xfer addr=%h wstrb=%b wdata=%h rdata=%h lat=%0d", addr, wstrb, wdata, rdata, lat);
    endtask

    logic [31:0] rd;
    logic [31:0] c0;
    int          lat;
    logic        dropped;

    initial begin
        rst_n = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        uart_ready = 1'b0;
        uart_rdata = 32'd0;
        repeat (3) @(posedge clk_in);
        #1;
        check_val("rst_ready", {31'd0, mem_ready}, 32'd0);
        check_val("rst_rdata", mem_rdata, 32'd0);
        check_val("rst_leds", {28'd0, leds}, 32'hF);
        check_val("rst_uart_sel", {31'd0, uart_sel}, 32'd0);
        dut.mem_array[0] = 32'h0000_0093;
        dut.mem_array[4] = 32'h0000_0000;
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;

        // SRAM read with latency and single-cycle pulse
        bus_xfer(32'h0000_0000, 32'd0, 4'b0000, rd, lat, dropped);
        check_val("sram_rd0", rd, 32'h0000_0093);
        check_val("sram_lat", lat, 32'd1);
        check_val("sram_pulse_drop", {31'd0, dropped}, 32'd1);

        // Partial byte write
        bus_xfer(32'h0000_0010, 32'hAABB_CCDD, 4'b0101, rd, lat, dropped);
        check_val("sram_wr_lat", lat, 32'd1);
        bus_xfer(32'h0000_0010, 32'd0, 4'b0000, rd, lat, dropped);
        check_val("sram_strb_rd", rd, 32'h00BB_00DD);
        bus_xfer(32'h0000_8010, 32'd0, 4'b0000, rd, lat, dropped);
        check_val("sram_alias_rd", rd, 32'h00BB_00DD);

        // LED register
        bus_xfer(32'h8000_0000, 32'h0000_0035, 4'b0001, rd, lat, dropped);
        check_val("led_leds", {28'd0, leds}, 32'hA);
        bus_xfer(32'h8000_0000, 32'd0, 4'b0000, rd, lat, dropped);
        check_val("led_rd", rd, 32'h0000_0035);
        bus_xfer(32'h8000_0000, 32'h0000_00FF, 4'b0010, rd, lat, dropped);
        bus_xfer(32'h8000_0000, 32'd0, 4'b0000, rd, lat, dropped);
        check_val("led_nostrb_rd", rd, 32'h0000_0035);

        // Error responder
        bus_xfer(32'h9000_0000, 32'd0, 4'b0000, rd, lat, dropped);
        check_val("err_rd", rd, 32'd0);
        check_val("err_lat", lat, 32'd1);
        bus_xfer(32'h9000_0000, 32'hFFFF_FFFF, 4'b1111, rd, lat, dropped);
        check_val("err_wr_lat", lat, 32'd1);
        check_val("err_wr_leds", {28'd0, leds}, 32'hA);
        bus_xfer(32'h0000_0000, 32'd0, 4'b0000, rd, lat, dropped);
        check_val("err_wr_sram", rd, 32'h0000_0093);

        // UART pass-through
        mem_addr = 32'h8000_000C;
        mem_valid = 1'b1;
        uart_rdata = 32'h1234_5678;
        #1;
        check_val("uart_sel", {31'd0, uart_sel}, 32'd1);
        check_val("uart_addr", {28'd0, uart_addr}, 32'hC);
        check_val("uart_noready", {31'd0, mem_ready}, 32'd0);
        uart_ready = 1'b1;
        #1;
        check_val("uart_ready", {31'd0, mem_ready}, 32'd1);
        check_val("uart_rdata", mem_rdata, 32'h1234_5678);
        uart_ready = 1'b0;
        mem_addr = 32'h8000_0010;
        #1;
        check_val("uart_sel_off", {31'd0, uart_sel}, 32'd0);
        mem_valid = 1'b0;
        @(posedge clk_in);
        #1;

        // Cycle counter (or error responder when not built)
        bus_xfer(32'h8000_0010, 32'd0, 4'b0000, c0, lat, dropped);
        repeat (8) @(posedge clk_in);
        #1;
        bus_xfer(32'h8000_0010, 32'd0, 4'b0000, rd, lat, dropped);
`ifdef CYCLE_COUNTER_EN
        check_val("cnt_delta", rd - c0, 32'd10);
`else
        check_val("cnt_off_rd0", c0, 32'd0);
        check_val("cnt_off_rd1", rd, 32'd0);
`endif

        // Reset in mid-transfer
        mem_addr = 32'h0000_0000;
        mem_wstrb = 4'b0000;
        mem_valid = 1'b1;
        @(posedge clk_in);
        #1;
        check_val("mid_ready_pre", {31'd0, mem_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_ready_rst", {31'd0, mem_ready}, 32'd0);
        check_val("mid_leds_rst", {28'd0, leds}, 32'hF);
        mem_wdata = 32'hDEAD_BEEF;
        mem_wstrb = 4'b1111;
        repeat (2) @(posedge clk_in);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        bus_xfer(32'h0000_0000, 32'd0, 4'b0000, rd, lat, dropped);
        check_val("mid_sram_kept", rd, 32'h0000_0093);
        bus_xfer(32'h8000_0000, 32'd0, 4'b0000, rd, lat, dropped);
        check_val("mid_led_rd", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
